// File: rtl/apb_mi_pkg.sv
// -----------------------------------------------------------------------------
// apb_mi_pkg
//   Shared definitions for the APB master interface and the slave-side decoder:
//   FSM state encoding, the default abort data word and small width helpers.
//   No ports (package).
// -----------------------------------------------------------------------------
package apb_mi_pkg;

  // Bus phase of the single outstanding APB transfer. The encoding is shared
  // with the decoder, so the values are fixed explicitly.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Read data returned to a master whose transfer was aborted by the watchdog.
  localparam logic [31:0] TIMEOUT_CODE_DEFAULT = 32'hDEADDEAD;

  // Width of an index into n items; never below 1 so a vector can be declared.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Watchdog counter width, clog2(timeout+1); a disabled watchdog (0) still
  // gets a 1-bit counter so the declaration stays legal.
  function automatic int unsigned wd_width(input int unsigned timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage : apb_mi_pkg

// File: rtl/apb_mi_rr_arb.sv
// -----------------------------------------------------------------------------
// apb_mi_rr_arb
//   Combinational round-robin arbiter. The requester closest after last_i
//   (wrapping modulo N) wins; last_i itself has the lowest priority, so a lone
//   requester always wins whatever last_i holds.
// Ports
//   req_i    in  N    request vector (already masked for eligibility)
//   last_i   in  IW   index of the previously served requester
//   grant_o  out IW   index of the winner (only meaningful when any_o=1)
//   any_o    out 1    at least one request is present
// -----------------------------------------------------------------------------
module apb_mi_rr_arb
  import apb_mi_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] grant_o,
  output logic          any_o
);

  localparam int NI = int'(N);

  // Offsets are scanned from farthest to nearest so the nearest requester is
  // the last assignment and therefore the winner.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    grant_o = last_i;
    any_o   = 1'b0;
    for (int off = NI; off >= 1; off--) begin
      if (req_i[(int'(last_i) + off) % NI]) begin
        grant_o = IW'((int'(last_i) + off) % NI);
        any_o   = 1'b1;
      end
    end
  end

endmodule : apb_mi_rr_arb

// File: rtl/apb_mi.sv
// -----------------------------------------------------------------------------
// apb_mi
//   APB master interface in front of the slave-side decoder. Arbitrates
//   MST_NUM request ports round-robin, latches the winner's command, runs one
//   SETUP/ACCESS transfer on the shared bus and returns the result to the
//   winner as a one-cycle done pulse. A wait-state watchdog aborts transfers
//   whose ACCESS phase never sees pready_s.
// Ports
//   clk          in   1                   clock, all state on rising edge
//   rst          in   1                   asynchronous active-high reset
//   m_req        in   MST_NUM             per-master request, held until m_done
//   m_write      in   MST_NUM             per-master direction, 1 = write
//   m_addr       in   MST_NUM*ADDR_WIDTH  master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   m_wdata      in   MST_NUM*DATA_WIDTH  master i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_done       out  MST_NUM             one-cycle completion pulse to the winner
//   m_err        out  1                   with m_done: 1 = watchdog abort
//   m_rdata      out  DATA_WIDTH          read data, held until next completion
//   psel_arb     out  1                   APB select
//   penable_arb  out  1                   APB enable
//   pwrite_mi    out  1                   APB direction
//   paddr_mi     out  ADDR_WIDTH          APB address
//   pwdata_mi    out  DATA_WIDTH          APB write data
//   prdata_s     in   DATA_WIDTH          read data from decoder
//   pready_s     in   1                   ready from decoder
// -----------------------------------------------------------------------------
module apb_mi
  import apb_mi_pkg::*;
#(
  parameter int unsigned           MST_NUM      = 2,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           ADDR_WIDTH   = 16,
  parameter int unsigned           TIMEOUT      = 255,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_CODE = DATA_WIDTH'(TIMEOUT_CODE_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MST_NUM-1:0]            m_req,
  input  logic [MST_NUM-1:0]            m_write,
  input  logic [MST_NUM*ADDR_WIDTH-1:0] m_addr,
  input  logic [MST_NUM*DATA_WIDTH-1:0] m_wdata,
  output logic [MST_NUM-1:0]            m_done,
  output logic                          m_err,
  output logic [DATA_WIDTH-1:0]         m_rdata,
  output logic                          psel_arb,
  output logic                          penable_arb,
  output logic                          pwrite_mi,
  output logic [ADDR_WIDTH-1:0]         paddr_mi,
  output logic [DATA_WIDTH-1:0]         pwdata_mi,
  input  logic [DATA_WIDTH-1:0]         prdata_s,
  input  logic                          pready_s
);

  localparam int unsigned IW = idx_width(MST_NUM);
  localparam int unsigned WW = wd_width(TIMEOUT);

  // Count value held during the TIMEOUT-th consecutive low ACCESS cycle.
  localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] LAST_RST = IW'(MST_NUM - 1);

  apb_state_e              state_q,   state_d;
  logic [IW-1:0]           grant_q,   grant_d;
  logic [IW-1:0]           last_q,    last_d;
  logic [WW-1:0]           wd_q,      wd_d;
  logic                    psel_q,    psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q,  pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,   paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,  pwdata_d;
  logic [MST_NUM-1:0]      done_q,    done_d;
  logic                    err_q,     err_d;
  logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;

  logic [MST_NUM-1:0]      eligible;
  logic [IW-1:0]           arb_grant;
  logic                    arb_any;

  // The master just served still holds req during its done cycle; masking it
  // keeps that stale request from starting a second transfer.
  assign eligible = m_req & ~done_q;

  apb_mi_rr_arb #(
    .N  (MST_NUM),
    .IW (IW)
  ) u_arb (
    .req_i   (eligible),
    .last_i  (last_q),
    .grant_o (arb_grant),
    .any_o   (arb_any)
  );

  // Next-state logic for the FSM and every registered output.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    wd_d      = wd_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    done_d    = '0;      // completion flags are single-cycle pulses
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d   = arb_grant;
          pwrite_d  = m_write[arb_grant];
          paddr_d   = m_addr[int'(arb_grant)*ADDR_WIDTH +: ADDR_WIDTH];
          pwdata_d  = m_wdata[int'(arb_grant)*DATA_WIDTH +: DATA_WIDTH];
          wd_d      = '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        // pready is tested first so a ready arriving on the expiry cycle
        // completes normally instead of aborting.
        if (pready_s) begin
          rdata_d          = prdata_s;
          done_d[grant_q]  = 1'b1;
          err_d            = 1'b0;
          last_d           = grant_q;
          psel_d           = 1'b0;
          penable_d        = 1'b0;
          state_d          = ST_IDLE;
        end else if (TIMEOUT != 0 && wd_q == WD_LAST) begin
          rdata_d          = TIMEOUT_CODE;
          done_d[grant_q]  = 1'b1;
          err_d            = 1'b1;
          last_d           = grant_q;
          psel_d           = 1'b0;
          penable_d        = 1'b0;
          state_d          = ST_IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Reset clears psel/penable asynchronously, abandoning any transfer in
  // flight without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= LAST_RST;
      wd_q      <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign m_done      = done_q;
  assign m_err       = err_q;
  assign m_rdata     = rdata_q;
  assign psel_arb    = psel_q;
  assign penable_arb = penable_q;
  assign pwrite_mi   = pwrite_q;
  assign paddr_mi    = paddr_q;
  assign pwdata_mi   = pwdata_q;

endmodule : apb_mi

// File: tb/tb_apb_mi.sv
// -----------------------------------------------------------------------------
// tb_apb_mi
//   Self-checking bench for apb_mi (2 masters, TIMEOUT=4). Inputs are driven
//   and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_apb_mi;

  localparam int          MN   = 2;
  localparam int          DW   = 32;
  localparam int          AW   = 16;
  localparam int          TO   = 4;
  localparam logic [31:0] CODE = 32'hDEADDEAD;

  logic              clk = 1'b0;
  logic              rst;
  logic [MN-1:0]     m_req, m_write, m_done;
  logic [MN*AW-1:0]  m_addr;
  logic [MN*DW-1:0]  m_wdata;
  logic              m_err;
  logic [DW-1:0]     m_rdata, pwdata_mi, prdata_s;
  logic              psel_arb, penable_arb, pwrite_mi, pready_s;
  logic [AW-1:0]     paddr_mi;

  always #5 clk = ~clk;

  apb_mi #(
    .MST_NUM      (MN),
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .TIMEOUT      (TO),
    .TIMEOUT_CODE (CODE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req       (m_req),
    .m_write     (m_write),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_done      (m_done),
    .m_err       (m_err),
    .m_rdata     (m_rdata),
    .psel_arb    (psel_arb),
    .penable_arb (penable_arb),
    .pwrite_mi   (pwrite_mi),
    .paddr_mi    (paddr_mi),
    .pwdata_mi   (pwdata_mi),
    .prdata_s    (prdata_s),
    .pready_s    (pready_s)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_cmd(input int m, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    m_write[m]          = wr;
    m_addr[m*AW +: AW]  = a;
    m_wdata[m*DW +: DW] = d;
  endtask

  typedef struct {
    int          mst;
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          lows;        // ACCESS cycles with pready low before ready
    logic [31:0] prdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          exp_access;  // ACCESS cycles expected before m_done
  } vec_t;

  vec_t tbl[6];

  // One isolated transfer from a single master.
  task automatic run_vec(input vec_t v);
    int acc;
    bit done;
    logic [MN-1:0] exp_done;
    exp_done = '0;
    exp_done[v.mst] = 1'b1;
    @(negedge clk);
    drive_cmd(v.mst, v.wr, v.addr, v.wdata);
    m_req[v.mst] = 1'b1;
    pready_s = 1'b1;                 // must be ignored in IDLE and SETUP
    prdata_s = 32'h0BAD0BAD;
    @(negedge clk);
    check("setup_psel",    psel_arb,    1'b1);
    check("setup_penable", penable_arb, 1'b0);
    check("setup_paddr",   paddr_mi,    v.addr);
    check("setup_pwrite",  pwrite_mi,   v.wr);
    check("setup_pwdata",  pwdata_mi,   v.wdata);
    drive_cmd(v.mst, ~v.wr, ~v.addr, ~v.wdata);   // must be ignored now
    acc  = 0;
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_done != '0) begin
        done = 1'b1;
        break;
      end
      acc++;
      check("access_phase", {psel_arb, penable_arb}, 2'b11);
      pready_s = (acc > v.lows);
      prdata_s = v.prdata;
    end
    check("done_seen",     done,     1'b1);
    check("access_cycles", acc,      v.exp_access);
    check("done_vec",      m_done,   exp_done);
    check("done_err",      m_err,    v.exp_err);
    check("done_rdata",    m_rdata,  v.exp_rdata);
    check("done_psel",     psel_arb, 1'b0);
    check("hold_paddr",    paddr_mi, v.addr);
    m_req[v.mst] = 1'b0;
    pready_s = 1'b0;
    @(negedge clk);
    check("done_pulse",    m_done,   '0);
    check("rdata_held",    m_rdata,  v.exp_rdata);
  endtask

  // Random-phase reference: transaction-level phase tracker.
  int              ph;        // 0 idle, 1 setup, 2 access, 3 idle with done pulse
  int              win, last, lows;
  bit              pend[MN];
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata, held_rdata;
  bit              lat_wr, exp_err;

  initial begin
    int            order[$];
    bit            seen;
    logic [MN-1:0] elig, onehot;

    rst = 1'b1; m_req = '0; m_write = '0; m_addr = '0; m_wdata = '0;
    pready_s = 1'b0; prdata_s = '0;
    repeat (2) @(negedge clk);
    check("rst_done",    m_done,      '0);
    check("rst_err",     m_err,       1'b0);
    check("rst_rdata",   m_rdata,     '0);
    check("rst_psel",    psel_arb,    1'b0);
    check("rst_penable", penable_arb, 1'b0);
    check("rst_pwrite",  pwrite_mi,   1'b0);
    check("rst_paddr",   paddr_mi,    '0);
    check("rst_pwdata",  pwdata_mi,   '0);
    rst = 1'b0;

    // ---- table-driven single transfers ----
    tbl[0] = '{0, 1'b1, 16'h0010, 32'h12345678, 0,  32'h11110000, 1'b0, 32'h11110000, 1};
    tbl[1] = '{1, 1'b0, 16'h4004, 32'h00000000, 3,  32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 4};
    tbl[2] = '{1, 1'b0, 16'h4008, 32'h00000001, 0,  32'h3C3C3C3C, 1'b0, 32'h3C3C3C3C, 1};
    tbl[3] = '{0, 1'b1, 16'h0020, 32'hFEEDBEEF, 99, 32'h55555555, 1'b1, CODE,         TO};
    tbl[4] = '{0, 1'b0, 16'h0030, 32'h00000002, 3,  32'h77665544, 1'b0, 32'h77665544, 4};
    tbl[5] = '{1, 1'b1, 16'h4010, 32'h89ABCDEF, 1,  32'h00000000, 1'b0, 32'h00000000, 2};
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // ---- both masters requesting continuously: alternate grants ----
    @(negedge clk);
    drive_cmd(0, 1'b1, 16'h0100, 32'h0000AAAA);
    drive_cmd(1, 1'b0, 16'h0200, 32'h0000BBBB);
    m_req = 2'b11;
    pready_s = 1'b1;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(negedge clk);
      if (psel_arb && !penable_arb) order.push_back((paddr_mi == 16'h0200) ? 1 : 0);
      m_req = ~m_done;
    end
    check("rr_count", order.size(), 4);
    for (int i = 0; i < order.size(); i++) check("rr_order", order[i], i % 2);
    m_req = '0;                      // dropped mid-transfer: must still complete
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_done != '0) begin seen = 1'b1; break; end
    end
    check("drop_req_done", m_done, 2'b10);
    pready_s = 1'b0;
    @(negedge clk);

    // ---- reset during ACCESS ----
    drive_cmd(1, 1'b0, 16'h4444, 32'h0);
    m_req = 2'b10;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (psel_arb && penable_arb) begin seen = 1'b1; break; end
    end
    check("rst_reach_access", seen, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_psel",    psel_arb,    1'b0);
    check("rst_async_penable", penable_arb, 1'b0);
    drive_cmd(0, 1'b1, 16'h0AAA, 32'hCAFEF00D);
    m_req = 2'b11;
    @(negedge clk);
    check("rst_no_done", m_done,   '0);
    check("rst_paddr0",  paddr_mi, '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_setup", {psel_arb, penable_arb}, 2'b10);
    check("post_rst_m0",    paddr_mi, 16'h0AAA);
    m_req = '0;
    pready_s = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_done != '0) break;
    end
    check("post_rst_done", m_done, 2'b01);
    pready_s = 1'b0;

    // ---- randomized traffic against the phase model ----
    @(negedge clk);
    rst = 1'b1;
    m_req = '0;
    @(negedge clk);
    rst = 1'b0;
    ph = 0; win = 0; last = MN - 1; lows = 0;
    lat_addr = '0; lat_wdata = '0; lat_wr = 1'b0; held_rdata = '0; exp_err = 1'b0;
    for (int i = 0; i < MN; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      // advance the model using the inputs present at the last rising edge
      case (ph)
        0, 3: begin
          elig = m_req;
          if (ph == 3) elig[win] = 1'b0;
          ph = 0;
          for (int off = 1; off <= MN; off++) begin
            if (elig[(last + off) % MN]) begin
              win       = (last + off) % MN;
              lat_addr  = m_addr[win*AW +: AW];
              lat_wdata = m_wdata[win*DW +: DW];
              lat_wr    = m_write[win];
              ph        = 1;
              break;
            end
          end
        end
        1: begin
          ph   = 2;
          lows = 0;
        end
        default: begin
          if (pready_s) begin
            ph = 3; exp_err = 1'b0; held_rdata = prdata_s; last = win;
          end else begin
            lows++;
            if (lows == TO) begin
              ph = 3; exp_err = 1'b1; held_rdata = CODE; last = win;
            end
          end
        end
      endcase
      onehot = '0;
      if (ph == 3) onehot[win] = 1'b1;
      check("rnd_psel",    psel_arb,    (ph == 1 || ph == 2));
      check("rnd_penable", penable_arb, (ph == 2));
      check("rnd_done",    m_done,      onehot);
      if (ph == 3) check("rnd_err", m_err, exp_err);
      check("rnd_rdata",   m_rdata,     held_rdata);
      check("rnd_paddr",   paddr_mi,    lat_addr);
      check("rnd_pwdata",  pwdata_mi,   lat_wdata);
      check("rnd_pwrite",  pwrite_mi,   lat_wr);
      // drive the next cycle's inputs
      for (int i = 0; i < MN; i++) begin
        if (ph == 3 && win == i) begin
          pend[i]  = 1'b0;
          m_req[i] = 1'b0;
        end else if (!pend[i]) begin
          if ($urandom_range(3) == 0) begin
            pend[i]  = 1'b1;
            m_req[i] = 1'b1;
            drive_cmd(i, 1'($urandom_range(1)), AW'($urandom), $urandom);
          end
        end else if ((ph == 1 || ph == 2) && win == i) begin
          drive_cmd(i, 1'($urandom_range(1)), AW'($urandom), $urandom);
          if ($urandom_range(7) == 0) m_req[i] = 1'b0;
        end
      end
      pready_s = ($urandom_range(2) == 0);
      prdata_s = $urandom;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_apb_mi
